// File: rtl/lut_reader_pkg.sv
// lut_reader_pkg
// Shared types and constants for the LUT truth-table reader.
//   state_t     : reader FSM states
//   NUM_VECTORS : number of input vectors swept (3-input LUT -> 8)
//   IDX_W       : width of the vector index
//   LAST_IDX    : index of the final vector in a sweep
package lut_reader_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// settle_timer
// Down-counter that sets the settle wait between driving a vector and
// sampling the cell output.
//   clk, rst_n : clock, async active-low reset
//   load       : load counter with load_val
//   load_val   : settle cycle count
//   count      : decrement this cycle (saturates at zero)
//   expire     : counter currently holds 1, i.e. this is the last wait cycle
module settle_timer #(
    parameter int SETTLE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                count,
    output logic                expire
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - SETTLE_W'(1);
        end
    end

    assign expire = (cnt == SETTLE_W'(1));

endmodule

// File: rtl/lut_truth_reader.sv
// lut_truth_reader
// Sweeps all eight input vectors of a 3-input LUT cell, waits a programmable
// number of settle cycles per vector, samples the cell output and builds its
// truth table, then compares it against a reference table.
//   clk, rst_n            : clock, async active-low reset
//   start                 : one-cycle read request, honoured only when idle
//   settle_cycles         : wait cycles per vector (latched on start)
//   expected              : reference truth table (latched on start)
//   dut_a, dut_b, dut_sel : stimulus to the cell, {sel,b,a} = vector index
//   dut_c                 : cell output, same clock domain
//   busy                  : read in progress (through the done cycle)
//   done                  : one-cycle completion pulse
//   truth_table           : captured table, bit i = dut_c for vector i
//   match                 : truth_table == latched reference, valid from done
module lut_truth_reader
    import lut_reader_pkg::*;
#(
    parameter int SETTLE_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SETTLE_W-1:0]    settle_cycles,
    input  logic [NUM_VECTORS-1:0] expected,
    output logic                   dut_a,
    output logic                   dut_b,
    output logic                   dut_sel,
    input  logic                   dut_c,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] truth_table,
    output logic                   match
);

    state_t state, state_nxt;

    logic [IDX_W-1:0]       idx;
    logic [SETTLE_W-1:0]    settle_q;
    logic [NUM_VECTORS-1:0] exp_q;
    logic [NUM_VECTORS-1:0] tt_nxt;
    logic                   accept;
    logic                   last;
    logic                   tmr_load;
    logic                   tmr_count;
    logic                   tmr_expire;

    assign accept = (state == ST_IDLE) && start;
    assign last   = (idx == LAST_IDX);

    settle_timer #(
        .SETTLE_W (SETTLE_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (settle_q),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_DRIVE;
            ST_DRIVE: begin
                tmr_load  = 1'b1;
                state_nxt = (settle_q != '0) ? ST_SETTLE : ST_SAMPLE;
            end
            ST_SETTLE: begin
                tmr_count = 1'b1;
                if (tmr_expire) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: state_nxt = last ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Table with the current sample merged in; match is computed from it so
    // the comparison is already valid in the done cycle.
    always_comb begin
        tt_nxt      = truth_table;
        tt_nxt[idx] = dut_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            settle_q    <= '0;
            exp_q       <= '0;
            truth_table <= '0;
            match       <= 1'b0;
        end else if (accept) begin
            idx         <= '0;
            settle_q    <= settle_cycles;
            exp_q       <= expected;
            truth_table <= '0;
            match       <= 1'b0;
        end else if (state == ST_SAMPLE) begin
            truth_table <= tt_nxt;
            if (last) match <= (tt_nxt == exp_q);
            else      idx   <= idx + IDX_W'(1);
        end
    end

    // idx only moves on start and after a sample, so it is also the
    // "last vector driven" while idle.
    assign {dut_sel, dut_b, dut_a} = idx;
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule
